seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller that shares one BCD-to-7-segment converter among `DIGITS` common-anode/cathode digit positions. It holds a frame of BCD digits, presents one digit at a time on `bcd_out` to the shared converter, and drives the matching one-hot `digit_en`. It inserts inter-digit blanking against ghosting, optionally suppresses leading zeros, and applies new display values only at frame boundaries so a frame never tears. It sits between the application logic producing counts and the converter plus digit drivers on the board.

## Interface

Parameters:
- `DIGITS`, 4: number of digit positions (≥2); digit 0 is least significant.
- `DIV`, 50000: clock cycles each digit is shown (≥1).
- `BLANK`, 2: all-off clock cycles after each digit (≥0; 0 removes the BLANK state).

Ports (`clk` and `rst`: one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  single-cycle strobe; captures `value`, `dp_in`, `lz_en`.
- `value`  in  4*DIGITS  BCD digits; digit i = `value[4i+3:4i]`.
- `dp_in`  in  DIGITS  decimal point per digit.
- `lz_en`  in  1  leading-zero suppression enable.
- `bcd_out`  out  4  code to shared converter; 4'hF = blank, because the converter decodes 4'hA–4'hF as all segments off.
- `digit_en`  out  DIGITS  one-hot active-high digit enable; all-zero while blanking.
- `dp`  out  1  decimal point for the enabled digit.
- `frame_done`  out  1  one-cycle pulse when scanning wraps back to digit 0.

## Operation

- Registers: active frame (value, dp, lz_en), shadow frame, `pending` flag, digit index `idx`, slot counter `cnt`, FSM state.
- FSM states:
  - SHOW: `digit_en[idx]`=1. Lasts DIV cycles, then goes to BLANK, or to the next digit's SHOW if BLANK=0.
  - BLANK: `digit_en`=0, `bcd_out`=4'hF, `dp`=0. Lasts BLANK cycles, then goes to SHOW with `idx` advanced.
- `idx` increments 0→DIGITS-1 and wraps to 0.
- `cnt` width is clog2(max(DIV,BLANK)+1). It counts 0..N-1 in each state and clears on every state or digit change.
- Load handling:
  - `load`=1 writes the shadow frame and sets `pending`.
  - A further `load` while `pending` overwrites the shadow; last write wins.
- Frame transfer, on the edge where `idx` wraps DIGITS-1→0:
  - If `pending`, the shadow is copied to the active frame and `pending` clears.
  - If `load` is high on that same edge, the incoming `value` goes straight to the active frame, bypassing the shadow, and `pending` ends 0.
- Leading-zero suppression: digit i (i≥1) shows 4'hF with `dp`=0 when active `lz_en`=1 and every active digit from DIGITS-1 down to i is 4'h0. Digit 0 is never suppressed.
- Non-BCD digits (A–F) pass through unchanged; the converter blanks them.

## Timing

- Reset values:
  - outputs: `digit_en`=0, `bcd_out`=4'hF, `dp`=0, `frame_done`=0.
  - internal: active and shadow frames 0, `lz_en`=0, `pending`=0, `idx`=0, `cnt`=0, state SHOW.
- All outputs are registered.
- Let E0 be the first rising edge with `rst`=0. Starting at E0:
  - digit 0 is shown after edges E0..E(DIV-1).
  - all-off after edges E(DIV)..E(DIV+BLANK-1).
  - digit 1 is shown after edge E(DIV+BLANK).
- Frame period is DIGITS*(DIV+BLANK) cycles.
- `frame_done` is high for exactly the cycle after the edge that re-enters digit 0. It is not asserted on leaving reset.
- Load latency: a new value appears on the first digit-0 SHOW after the next wrap. It never appears mid-frame.
- `rst` asserted mid-frame:
  - takes effect on the next edge and returns all registers to reset values.
  - any pending load is discarded.
- `load` and `rst` on the same edge: reset wins.

## Test plan

All scenarios use DIGITS=4, DIV=4, BLANK=1.

1. **Reset release:** `rst` high 3 cycles, then low.
   - Reset: `digit_en`=0000, `bcd_out`=F.
   - Then `digit_en` steps 0001×4, 0000×1, 0010×4, 0000×1, 0100, 1000, back to 0001.
   - `frame_done` pulses once every 20 cycles.
2. **Load mid-frame:** `value`=16'h1234, `dp_in`=0100, pulsed during digit 1.
   - Current frame still shows 0s.
   - From the next digit-0 slot: `bcd_out` 4,3,2,1 across digits 0..3; `dp`=1 only on digit 2.
3. **Double load:** 16'h1111 then 16'h2222 within one frame.
   - Next frame shows only 2222; `pending` cleared after wrap.
4. **Load on wrap edge:** `load` coincides with the frame wrap.
   - New value shown in the digit-0 slot that starts on that edge.
5. **Leading zeros:** `lz_en`=1 with `value`=16'h0070, then 16'h0000.
   - 0070: digits 3 and 2 give F; digits 1 and 0 give 7 and 0.
   - 0000: digits 3..1 give F; digit 0 gives 0.
6. **Mid-frame reset:** `rst` asserted during digit 2 with a load pending.
   - Outputs all-off the next cycle.
   - After release, scanning restarts at digit 0 showing 0000; the pending value is lost.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for a DIGITS-position 7-segment display that
// shares a single BCD-to-7-segment converter. It holds an active frame of BCD
// digits and walks through the positions one at a time. Each position is shown
// for DIV cycles and followed by BLANK all-off cycles to suppress ghosting.
// Leading zeros can optionally be suppressed. New values are double-buffered
// and only take effect at a frame wrap, so a frame never shows a mix of values.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous, active-high reset
//   load       one-cycle strobe capturing value / dp_in / lz_en
//   value      BCD digits, digit i = value[4i+3:4i], digit 0 least significant
//   dp_in      decimal point per digit
//   lz_en      leading-zero suppression enable
//   bcd_out    code for the shared converter (4'hF = blank)
//   digit_en   one-hot digit enable, all-zero while blanking
//   dp         decimal point for the enabled digit
//   frame_done one-cycle pulse in the first cycle digit 0 is shown again
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int MAXN = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = $clog2(MAXN + 1);
  localparam int IW   = $clog2(DIGITS);
  localparam logic [CW-1:0]     SHOW_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]     BLANK_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIGIT0     = DIGITS'(1);

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [IW-1:0]        idx_r;
  logic [4*DIGITS-1:0]  act_val_r;
  logic [DIGITS-1:0]    act_dp_r;
  logic                 act_lz_r;
  logic [4*DIGITS-1:0]  sh_val_r;
  logic [DIGITS-1:0]    sh_dp_r;
  logic                 sh_lz_r;
  logic                 pending_r;
  logic                 wrap_r;

  logic                 slot_end_s;
  logic                 wrap_s;
  logic [IW-1:0]        next_idx_s;
  logic [3:0]           cur_digit_s;
  logic                 zero_run_s;
  logic                 suppress_s;

  // Slot sequencing: end of a digit slot, frame wrap, next index, current digit.
  always_comb begin
    slot_end_s = 1'b0;
    case (state_r)
      // Without a blanking gap the SHOW slot itself ends the digit.
      ST_SHOW:  slot_end_s = (cnt_r == SHOW_LAST) && (BLANK == 0);
      ST_BLANK: slot_end_s = (cnt_r == BLANK_LAST);
      default:  slot_end_s = 1'b0;
    endcase
    wrap_s = slot_end_s && (idx_r == IDX_LAST);
    if (idx_r == IDX_LAST) begin
      next_idx_s = IW'(0);
    end else begin
      next_idx_s = idx_r + IW'(1);
    end
    cur_digit_s = act_val_r[{idx_r, 2'b00} +: 4];
  end

  // Leading-zero detection: walk from the top digit down, tracking whether
  // every digit so far is zero; digit 0 is never considered.
  always_comb begin
    zero_run_s = 1'b1;
    suppress_s = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run_s = zero_run_s & (act_val_r[4*i +: 4] == 4'h0);
      if (idx_r == IW'(i)) begin
        suppress_s = act_lz_r & zero_run_s;
      end else begin
        suppress_s = suppress_s;
      end
    end
  end

  // Scan FSM, frame buffering and registered outputs.
  // Outputs decode the state held before each edge, so the display trails the
  // internal index by one cycle; the active frame is swapped on the internal
  // wrap edge and is therefore already in place for the first digit-0 cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_SHOW;
      cnt_r      <= CW'(0);
      idx_r      <= IW'(0);
      act_val_r  <= {(4*DIGITS){1'b0}};
      act_dp_r   <= {DIGITS{1'b0}};
      act_lz_r   <= 1'b0;
      sh_val_r   <= {(4*DIGITS){1'b0}};
      sh_dp_r    <= {DIGITS{1'b0}};
      sh_lz_r    <= 1'b0;
      pending_r  <= 1'b0;
      wrap_r     <= 1'b0;
      bcd_out    <= 4'hF;
      digit_en   <= {DIGITS{1'b0}};
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state_r)
        ST_SHOW: begin
          if (cnt_r == SHOW_LAST) begin
            cnt_r <= CW'(0);
            if (BLANK == 0) begin
              state_r <= ST_SHOW;
              idx_r   <= next_idx_s;
            end else begin
              state_r <= ST_BLANK;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            cnt_r   <= CW'(0);
            state_r <= ST_SHOW;
            idx_r   <= next_idx_s;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= ST_SHOW;
          cnt_r   <= CW'(0);
          idx_r   <= IW'(0);
        end
      endcase

      // A load on the wrap edge bypasses the shadow and wins over any pending one.
      if (wrap_s) begin
        if (load) begin
          act_val_r <= value;
          act_dp_r  <= dp_in;
          act_lz_r  <= lz_en;
        end else if (pending_r) begin
          act_val_r <= sh_val_r;
          act_dp_r  <= sh_dp_r;
          act_lz_r  <= sh_lz_r;
        end else begin
          act_val_r <= act_val_r;
        end
        pending_r <= 1'b0;
      end else if (load) begin
        sh_val_r  <= value;
        sh_dp_r   <= dp_in;
        sh_lz_r   <= lz_en;
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end

      wrap_r     <= wrap_s;
      frame_done <= wrap_r;

      if (state_r == ST_SHOW) begin
        digit_en <= DIGIT0 << idx_r;
        if (suppress_s) begin
          bcd_out <= 4'hF;
          dp      <= 1'b0;
        end else begin
          bcd_out <= cur_digit_s;
          dp      <= act_dp_r[idx_r];
        end
      end else begin
        digit_en <= {DIGITS{1'b0}};
        bcd_out  <= 4'hF;
        dp       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with DIGITS=4, DIV=4, BLANK=1.
// The stimulus process pushes the hand-computed content of every digit slot it
// expects to appear; the monitor pops one entry each time a new digit slot
// starts and also checks slot lengths, blanking, frame_done and reset outputs.
module tb_seg_scan_ctrl;

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] bcd;
    logic       dp;
  } slot_t;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_en;
  logic        dp;
  logic        frame_done;

  slot_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    ecount   = 0;

  seg_scan_ctrl #(.DIGITS(4), .DIV(4), .BLANK(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .bcd_out    (bcd_out),
    .digit_en   (digit_en),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after edge Ek following reset release it holds k+1.
  always @(posedge clk) ecount <= rst ? 0 : ecount + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
  endtask

  // Push n slots of one frame; bcds holds the displayed codes, digit 3 in the top nibble.
  task automatic push_frame(input logic [15:0] bcds, input logic [3:0] dps, input int n);
    slot_t s;
    for (int i = 0; i < n; i++) begin
      s.en  = 4'b0001 << i;
      s.bcd = bcds[4*i +: 4];
      s.dp  = dps[i];
      exp_q.push_back(s);
    end
  endtask

  // Park on the negedge where inputs set now are sampled by edge Ek.
  task automatic at_edge(input int k);
    int guard;
    guard = 0;
    @(negedge clk);
    while (ecount != k && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (ecount != k) begin
      n_checks++;
      $display("FAIL at_edge timeout got %0d want %0d", ecount, k);
    end
  endtask

  task automatic do_load(input int k, input logic [15:0] v, input logic [3:0] d, input logic lz);
    at_edge(k);
    value = v;
    dp_in = d;
    lz_en = lz;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic       r;
    logic [3:0] prev_en;
    int         run;
    bit         after_rst;
    slot_t      cur;
    prev_en   = 4'b0000;
    run       = 0;
    after_rst = 1'b1;
    cur       = '0;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        check("reset_out", {23'd0, digit_en, bcd_out, dp}, {23'd0, 4'b0000, 4'hF, 1'b0});
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        prev_en   = 4'b0000;
        run       = 0;
        after_rst = 1'b1;
      end else if (digit_en != 4'b0000) begin
        if (digit_en != prev_en) begin
          if (prev_en == 4'b0000 && !after_rst) check("blank_len", run, 32'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL slot_underflow got en=%b bcd=%h want no slot", digit_en, bcd_out);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
            check("slot", {23'd0, digit_en, bcd_out, dp}, {23'd0, cur});
          end
          check("frame_done_start", {31'd0, frame_done},
                {31'd0, (cur.en == 4'b0001) && !after_rst});
          run       = 1;
          after_rst = 1'b0;
        end else begin
          check("slot_hold", {23'd0, digit_en, bcd_out, dp}, {23'd0, cur});
          check("frame_done_mid", {31'd0, frame_done}, 32'd0);
          run++;
        end
      end else begin
        if (prev_en != 4'b0000) begin
          check("show_len", run, 32'd4);
          run = 1;
        end else begin
          run++;
        end
        check("blank_out", {27'd0, bcd_out, dp, frame_done}, {27'd0, 4'hF, 1'b0, 1'b0});
      end
      prev_en = digit_en;
    end
  end

  // Stimulus
  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = 16'h0000;
    dp_in = 4'b0000;
    lz_en = 1'b0;

    // Reset release: frame 0 shows zeros.
    push_frame(16'h0000, 4'b0000, 4);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Load during digit 1 of frame 0: visible from frame 1.
    push_frame(16'h1234, 4'b0100, 4);
    do_load(6, 16'h1234, 4'b0100, 1'b0);

    // Double load in frame 1: frames 2 and 3 show only the last one.
    push_frame(16'h2222, 4'b0000, 4);
    push_frame(16'h2222, 4'b0000, 4);
    do_load(25, 16'h1111, 4'b0000, 1'b0);
    do_load(30, 16'h2222, 4'b0000, 1'b0);

    // Pending 9999 overridden by a load on the wrap edge (E79).
    push_frame(16'h5678, 4'b0001, 4);
    push_frame(16'h5678, 4'b0001, 4);
    do_load(70, 16'h9999, 4'b0000, 1'b0);
    do_load(79, 16'h5678, 4'b0001, 1'b0);

    // Leading zeros: 0070 with all dp set, then 0000, then non-BCD A.
    push_frame(16'hFF70, 4'b0011, 4);
    do_load(105, 16'h0070, 4'b1111, 1'b1);
    push_frame(16'hFFF0, 4'b0000, 4);
    do_load(125, 16'h0000, 4'b0000, 1'b1);
    push_frame(16'hFA00, 4'b0000, 3);
    do_load(145, 16'h0A00, 4'b0000, 1'b1);

    // Pending load then reset during digit 2 of frame 8.
    do_load(165, 16'h4321, 4'b1111, 1'b0);
    at_edge(171);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    push_frame(16'h0000, 4'b0000, 4);
    push_frame(16'h0000, 4'b0000, 1);
    rst = 1'b0;
    at_edge(23);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
